// File: rtl/natalius_prog_loader.sv
// Boot loader: frames a byte stream (SYNC, LEN_H, LEN_L, data, CSUM) into 16-bit SRAM writes and holds the CPU in reset until the image is verified.
// Latency: write strobe one cycle after the low data byte is accepted; done/err one cycle after the CSUM byte.
// Backpressure: rx_ready drops during the write cycle and in DONE/ERR; optional inter-byte timeout under PROG_LOADER_TIMEOUT_EN.
module natalius_prog_loader #(
    parameter logic [10:0] BASE_ADDR      = 11'd0,
    parameter int unsigned MEM_WORDS      = 2048,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        start,
    output logic        csb0,
    output logic        web0,
    output logic [1:0]  wmask0,
    output logic [10:0] addr0,
    output logic [15:0] din0,
    output logic        cpu_rst,
    output logic        done,
    output logic        err,
    output logic [11:0] words_loaded
);

    typedef enum logic [3:0] {
        S_SYNC, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  len_h, len_h_nxt;
    logic [7:0]  csum, csum_nxt;
    logic [11:0] n_words, n_words_nxt;
    logic [11:0] words_nxt;
    logic        rx_ready_nxt, csb0_nxt, web0_nxt, cpu_rst_nxt, done_nxt, err_nxt;
    logic [1:0]  wmask0_nxt;
    logic [10:0] addr0_nxt;
    logic [15:0] din0_nxt;
    logic        rx_fire;
    logic        tmo_hit;
    logic [12:0] len_full;

    assign rx_fire  = rx_valid && rx_ready;
    assign len_full = {1'b0, len_h[3:0], rx_data};

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_counting;

    assign tmo_counting = state inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM};
    assign tmo_hit      = tmo_counting && !rx_fire && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (rx_fire) begin
            tmo_cnt <= '0;
        end else if (tmo_counting && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // Without the timeout the parameter has no effect.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_nxt    = state;
        len_h_nxt    = len_h;
        csum_nxt     = csum;
        n_words_nxt  = n_words;
        words_nxt    = words_loaded;
        csb0_nxt     = 1'b1;
        web0_nxt     = 1'b1;
        wmask0_nxt   = 2'b00;
        addr0_nxt    = addr0;
        din0_nxt     = din0;
        cpu_rst_nxt  = cpu_rst;
        done_nxt     = done;
        err_nxt      = err;

        case (state)
            S_SYNC: begin
                if (rx_fire && rx_data == SYNC_BYTE) begin
                    state_nxt = S_LEN_H;
                    csum_nxt  = 8'd0;
                    words_nxt = 12'd0;
                end
            end
            S_LEN_H: begin
                if (rx_fire) begin
                    len_h_nxt = rx_data;
                    state_nxt = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (rx_fire) begin
                    if (len_h[7:4] != 4'd0 || len_full > 13'(MEM_WORDS)) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        n_words_nxt = len_full[11:0];
                        state_nxt   = (len_full == 13'd0) ? S_CSUM : S_DATA_H;
                    end
                end
            end
            S_DATA_H: begin
                if (rx_fire) begin
                    din0_nxt[15:8] = rx_data;
                    csum_nxt       = csum + rx_data;
                    state_nxt      = S_DATA_L;
                end
            end
            S_DATA_L: begin
                if (rx_fire) begin
                    din0_nxt[7:0] = rx_data;
                    csum_nxt      = csum + rx_data;
                    csb0_nxt      = 1'b0;
                    web0_nxt      = 1'b0;
                    wmask0_nxt    = 2'b11;
                    addr0_nxt     = BASE_ADDR + words_loaded[10:0];
                    state_nxt     = S_WRITE;
                end
            end
            S_WRITE: begin
                words_nxt = words_loaded + 12'd1;
                state_nxt = (words_nxt == n_words) ? S_CSUM : S_DATA_H;
            end
            S_CSUM: begin
                if (rx_fire) begin
                    if (8'(csum + rx_data) == 8'd0) begin
                        state_nxt   = S_DONE;
                        done_nxt    = 1'b1;
                        cpu_rst_nxt = 1'b0;
                    end else begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt   = S_SYNC;
                    done_nxt    = 1'b0;
                    err_nxt     = 1'b0;
                    cpu_rst_nxt = 1'b1;
                end
            end
            default: state_nxt = S_SYNC;
        endcase

        // A stalled sender aborts the frame wherever it is waiting.
        if (tmo_hit) begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
        end

        rx_ready_nxt = state_nxt inside {S_SYNC, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_SYNC;
            len_h        <= 8'd0;
            csum         <= 8'd0;
            n_words      <= 12'd0;
            words_loaded <= 12'd0;
            rx_ready     <= 1'b0;
            csb0         <= 1'b1;
            web0         <= 1'b1;
            wmask0       <= 2'b00;
            addr0        <= 11'd0;
            din0         <= 16'd0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            len_h        <= len_h_nxt;
            csum         <= csum_nxt;
            n_words      <= n_words_nxt;
            words_loaded <= words_nxt;
            rx_ready     <= rx_ready_nxt;
            csb0         <= csb0_nxt;
            web0         <= web0_nxt;
            wmask0       <= wmask0_nxt;
            addr0        <= addr0_nxt;
            din0         <= din0_nxt;
            cpu_rst      <= cpu_rst_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

endmodule
